register_bank: RTL and testbench
================================

Name: register_bank

Overview:
- Parametrised MIC-1 datapath register bank replacing individually instanced single registers.
- Holds NUM_REGS words of WIDTH bits. Written from the C bus via a multi-hot write mask, and loaded from memory via a valid/ready handshake.
- Drives one selected register onto the shared tri-state B bus, with byte zero/sign-extension modes (MBR path).
- Exposes always-on copies of H (A-bus input) and of every register.

Parameters:
- WIDTH, 32, data width of every register and bus.
- NUM_REGS, 10, number of registers (index 0 = H, 1 = MAR, 2 = MDR, 3 = MBR, 4 = PC, 5 = SP, 6 = LV, 7 = CPP, 8 = TOS, 9 = OPC).
- SEL_WIDTH, 4, width of bSelect; must satisfy 2**SEL_WIDTH >= NUM_REGS.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- cBus  input  WIDTH  C-bus write data.
- cWriteMask  input  NUM_REGS  bit i high = write cBus into register i at the next rising edge; multiple bits may be set.
- bEnable  input  1  B-bus drive enable.
- bSelect  input  SEL_WIDTH  index of the register driven onto the B bus.
- bReadMode  input  2  00 = full word; 01 = low byte zero-extended; 10 = low byte sign-extended; 11 = full word.
- bBus  output  WIDTH  tri-state B bus.
- bSelError  output  1  high while bEnable=1 and bSelect >= NUM_REGS.
- aOut  output  WIDTH  always-on contents of H (index 0).
- allOut  output  NUM_REGS*WIDTH  always-on contents of all registers; register i occupies bits [i*WIDTH +: WIDTH].
- memValid  input  1  memory has load data available.
- memTarget  input  1  0 = load into MDR, 1 = load into MBR.
- memData  input  WIDTH  memory load data.
- memReady  output  1  bank accepts the memory load this cycle.

Behaviour:
- Reset, synchronous and active-high, sampled at the rising edge:
  - All registers become 0, so aOut and allOut read 0 after that edge.
  - reset overrides cWriteMask and memValid in the same cycle.
  - memReady is 0 while reset is high.
- Write latency: a write occurs at the rising edge where cWriteMask[i]=1. The new value is visible on aOut, allOut and bBus from that edge on. There is no same-cycle bypass: reads always show pre-edge contents.
- Multi-hot mask: every selected register gets the same cBus value at the same edge.
- Memory handshake:
  - Target index T is 2 (MDR) when memTarget=0, and 3 (MBR) when memTarget=1.
  - memReady = !reset && !cWriteMask[T]. It is combinational on the current inputs.
  - A load transfers at a rising edge where memValid && memReady; register T takes memData.
  - If the C bus writes T in the same cycle, the C bus wins and memReady=0. The memory source must hold memValid, memTarget and memData until it sees memReady=1.
  - A load to T plus a C write to other registers in the same cycle: both complete.
  - memValid=0 has no effect; memReady may still be 1.
- B bus:
  - bEnable=0: bBus is all Z and bSelError=0.
  - bEnable=1 with bSelect < NUM_REGS: bBus drives the selected register, formatted by bReadMode:
    - 01: {WIDTH-8 zeros, reg[7:0]}.
    - 10: {WIDTH-8 copies of reg[7], reg[7:0]}.
    - 00 or 11: reg unchanged.
  - bEnable=1 with bSelect >= NUM_REGS: bBus is all Z and bSelError=1.
  - bBus, bSelError, aOut and allOut are combinational from the register contents and the select inputs. No clock latency.
- Registers with no write and no load hold their value indefinitely.
- Reset asserted while a memory load is pending: the load is dropped. After reset deasserts, the source must still see memReady=1 before the transfer completes.

Decomposition:
- Shared package register_bank_pkg holds:
  - register index constants (REG_H, REG_MAR, REG_MDR, REG_MBR, REG_PC, REG_SP, REG_LV, REG_CPP, REG_TOS, REG_OPC);
  - read-mode constants (READ_FULL, READ_BYTE_ZX, READ_BYTE_SX);
  - the memTarget encoding.
- One sub-module, bus_formatter: combinational mode-based extension of a WIDTH word. It is reusable for a future MBR-to-PC path.
- The storage loop stays in register_bank.

Test Plan:
- Reset: preload random values, assert reset for one edge -> allOut=0, aOut=0, memReady=0 during reset; bBus=Z with bEnable=0.
- Multi-hot write: cBus=32'hDEADBEEF, cWriteMask=10'b0000010001 (H, PC), one edge -> aOut=32'hDEADBEEF, PC slice=32'hDEADBEEF, others unchanged. In the same cycle before the edge, bSelect=0 with bEnable=1 shows the old H value.
- Read modes: MBR=32'h000000F0. bReadMode=01 -> bBus=32'h000000F0; 10 -> 32'hFFFFFFF0; 00 -> 32'h000000F0. MBR=32'h0000007F with mode 10 -> 32'h0000007F.
- Memory conflict: memValid=1, memTarget=0, memData=32'h12345678, cWriteMask[2]=1, cBus=32'hAAAA5555 -> memReady=0 and MDR=32'hAAAA5555 after the edge. Next cycle with the mask cleared -> memReady=1 and MDR=32'h12345678.
- Invalid select: bEnable=1, bSelect=4'd12 -> bBus=Z, bSelError=1. bEnable=0 -> bSelError=0.
- Reset during load: memValid=1 and reset=1 for one edge -> MBR=0, no transfer. Then reset=0 -> memReady=1, and the load completes at the following edge.

Source files
------------

// File: rtl/register_bank_pkg.sv
// Shared constants for the MIC-1 register bank: register indices, B-bus read
// modes and the memory-load target encoding.
package register_bank_pkg;

   localparam int REG_H   = 0;
   localparam int REG_MAR = 1;
   localparam int REG_MDR = 2;
   localparam int REG_MBR = 3;
   localparam int REG_PC  = 4;
   localparam int REG_SP  = 5;
   localparam int REG_LV  = 6;
   localparam int REG_CPP = 7;
   localparam int REG_TOS = 8;
   localparam int REG_OPC = 9;

   typedef enum logic [1:0] {
      READ_FULL     = 2'b00,
      READ_BYTE_ZX  = 2'b01,
      READ_BYTE_SX  = 2'b10,
      READ_FULL_ALT = 2'b11
   } read_mode_e;

   typedef enum logic {
      MEM_TO_MDR = 1'b0,
      MEM_TO_MBR = 1'b1
   } mem_target_e;

endpackage

// File: rtl/register_bank_bus_formatter.sv
// Combinational word formatter: passes a word through or reduces it to its
// low byte with zero or sign extension. Shared by any path that reads MBR.
module bus_formatter
   import register_bank_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] word_in,
   input  logic [1:0]       mode,
   output logic [WIDTH-1:0] word_out
);

   always_comb begin
      word_out = word_in;
      case (read_mode_e'(mode))
         READ_BYTE_ZX: word_out = {{(WIDTH-8){1'b0}}, word_in[7:0]};
         READ_BYTE_SX: word_out = {{(WIDTH-8){word_in[7]}}, word_in[7:0]};
         default:      word_out = word_in;
      endcase
   end

endmodule

// File: rtl/register_bank.sv
// MIC-1 datapath register bank: C-bus multi-hot writes, a valid/ready memory
// load into MDR or MBR, and a formatted tri-state B-bus read port.
module register_bank
   import register_bank_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int NUM_REGS  = 10,
   parameter int SEL_WIDTH = 4
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [WIDTH-1:0]          cBus,
   input  logic [NUM_REGS-1:0]       cWriteMask,
   input  logic                      bEnable,
   input  logic [SEL_WIDTH-1:0]      bSelect,
   input  logic [1:0]                bReadMode,
   output wire  [WIDTH-1:0]          bBus,
   output logic                      bSelError,
   output logic [WIDTH-1:0]          aOut,
   output logic [NUM_REGS*WIDTH-1:0] allOut,
   input  logic                      memValid,
   input  logic                      memTarget,
   input  logic [WIDTH-1:0]          memData,
   output logic                      memReady
);

   logic [WIDTH-1:0] regs_q [NUM_REGS];
   logic [WIDTH-1:0] regs_d [NUM_REGS];

   logic             target_conflict;
   logic             load_mdr;
   logic             load_mbr;
   logic             sel_valid;
   logic [WIDTH-1:0] sel_word;
   logic [WIDTH-1:0] fmt_word;

   // A C-bus write to the load target takes priority, so the load is held off.
   always_comb begin
      target_conflict = (mem_target_e'(memTarget) == MEM_TO_MBR) ? cWriteMask[REG_MBR]
                                                                 : cWriteMask[REG_MDR];
      memReady = !reset && !target_conflict;
      load_mdr = memValid && memReady && (mem_target_e'(memTarget) == MEM_TO_MDR);
      load_mbr = memValid && memReady && (mem_target_e'(memTarget) == MEM_TO_MBR);
   end

   always_comb begin
      for (int i = 0; i < NUM_REGS; i++) begin
         regs_d[i] = regs_q[i];
         if (cWriteMask[i]) begin
            regs_d[i] = cBus;
         end
      end
      if (load_mdr) begin
         regs_d[REG_MDR] = memData;
      end
      if (load_mbr) begin
         regs_d[REG_MBR] = memData;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

   always_comb begin
      sel_valid = int'(bSelect) < NUM_REGS;
      sel_word  = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (int'(bSelect) == i) begin
            sel_word = regs_q[i];
         end
      end
      bSelError = bEnable && !sel_valid;
      aOut      = regs_q[REG_H];
      for (int i = 0; i < NUM_REGS; i++) begin
         allOut[i*WIDTH +: WIDTH] = regs_q[i];
      end
   end

   bus_formatter #(
      .WIDTH (WIDTH)
   ) u_bus_formatter (
      .word_in  (sel_word),
      .mode     (bReadMode),
      .word_out (fmt_word)
   );

   assign bBus = (bEnable && sel_valid) ? fmt_word : {WIDTH{1'bz}};

endmodule

// File: tb/tb_register_bank.sv
// Directed self-checking bench for register_bank with hand-computed expectations.
module tb_register_bank;

   localparam int WIDTH     = 32;
   localparam int NUM_REGS  = 10;
   localparam int SEL_WIDTH = 4;

   logic                      clock;
   logic                      reset;
   logic [WIDTH-1:0]          cBus;
   logic [NUM_REGS-1:0]       cWriteMask;
   logic                      bEnable;
   logic [SEL_WIDTH-1:0]      bSelect;
   logic [1:0]                bReadMode;
   wire  [WIDTH-1:0]          bBus;
   logic                      bSelError;
   logic [WIDTH-1:0]          aOut;
   logic [NUM_REGS*WIDTH-1:0] allOut;
   logic                      memValid;
   logic                      memTarget;
   logic [WIDTH-1:0]          memData;
   logic                      memReady;

   int checkCount = 0;
   int errorCount = 0;
   logic [WIDTH-1:0] zWord;

   register_bank #(
      .WIDTH     (WIDTH),
      .NUM_REGS  (NUM_REGS),
      .SEL_WIDTH (SEL_WIDTH)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .cBus       (cBus),
      .cWriteMask (cWriteMask),
      .bEnable    (bEnable),
      .bSelect    (bSelect),
      .bReadMode  (bReadMode),
      .bBus       (bBus),
      .bSelError  (bSelError),
      .aOut       (aOut),
      .allOut     (allOut),
      .memValid   (memValid),
      .memTarget  (memTarget),
      .memData    (memData),
      .memReady   (memReady)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic checkOutput(input string tag, input logic [NUM_REGS*WIDTH-1:0] observed,
                              input logic [NUM_REGS*WIDTH-1:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Advance past one rising edge; inputs change and outputs are sampled 1ns later.
   task automatic applyStimulus();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [WIDTH-1:0] regSlice(input int idx);
      return allOut[idx*WIDTH +: WIDTH];
   endfunction

   initial begin
      zWord      = {WIDTH{1'bz}};
      reset      = 1'b1;
      cBus       = '0;
      cWriteMask = '0;
      bEnable    = 1'b0;
      bSelect    = '0;
      bReadMode  = 2'b00;
      memValid   = 1'b0;
      memTarget  = 1'b0;
      memData    = '0;
      applyStimulus();
      applyStimulus();
      reset = 1'b0;

      for (int i = 0; i < NUM_REGS; i++) begin
         cBus       = 32'h1000_0000 + 32'(i);
         cWriteMask = NUM_REGS'(1) << i;
         applyStimulus();
      end
      cWriteMask = '0;
      #1;
      checkOutput("preload_sp", 320'(regSlice(5)), 320'(32'h1000_0005));

      reset      = 1'b1;
      memValid   = 1'b1;
      cWriteMask = '1;
      cBus       = 32'h5A5A_5A5A;
      #1;
      checkOutput("ready_in_reset", 320'(memReady), 320'(1'b0));
      applyStimulus();
      reset      = 1'b0;
      memValid   = 1'b0;
      cWriteMask = '0;
      #1;
      checkOutput("reset_aout", 320'(aOut), 320'(32'h0));
      checkOutput("reset_allout", allOut, '0);
      checkOutput("bbus_disabled_z", 320'(bBus), 320'(zWord));
      checkOutput("selerr_disabled", 320'(bSelError), 320'(1'b0));

      cBus       = 32'h0000_CAFE;
      cWriteMask = 10'b0000000001;
      applyStimulus();
      cBus       = 32'hDEAD_BEEF;
      cWriteMask = 10'b0000010001;
      bEnable    = 1'b1;
      bSelect    = 4'd0;
      bReadMode  = 2'b00;
      #1;
      checkOutput("no_bypass_h", 320'(bBus), 320'(32'h0000_CAFE));
      applyStimulus();
      cWriteMask = '0;
      #1;
      checkOutput("multihot_h", 320'(aOut), 320'(32'hDEAD_BEEF));
      checkOutput("multihot_pc", 320'(regSlice(4)), 320'(32'hDEAD_BEEF));
      checkOutput("multihot_mdr_kept", 320'(regSlice(2)), 320'(32'h0));
      checkOutput("bbus_new_h", 320'(bBus), 320'(32'hDEAD_BEEF));

      cBus       = 32'h0000_00F0;
      cWriteMask = 10'b0000001000;
      applyStimulus();
      cWriteMask = '0;
      bSelect    = 4'd3;
      bReadMode  = 2'b01;
      #1;
      checkOutput("mode_zx", 320'(bBus), 320'(32'h0000_00F0));
      bReadMode = 2'b10;
      #1;
      checkOutput("mode_sx_neg", 320'(bBus), 320'(32'hFFFF_FFF0));
      bReadMode = 2'b00;
      #1;
      checkOutput("mode_full", 320'(bBus), 320'(32'h0000_00F0));
      cBus       = 32'h1234_56F0;
      cWriteMask = 10'b0000001000;
      applyStimulus();
      cWriteMask = '0;
      bReadMode  = 2'b11;
      #1;
      checkOutput("mode_full_alt", 320'(bBus), 320'(32'h1234_56F0));
      bReadMode = 2'b01;
      #1;
      checkOutput("mode_zx_upper", 320'(bBus), 320'(32'h0000_00F0));
      cBus       = 32'h0000_007F;
      cWriteMask = 10'b0000001000;
      applyStimulus();
      cWriteMask = '0;
      bReadMode  = 2'b10;
      #1;
      checkOutput("mode_sx_pos", 320'(bBus), 320'(32'h0000_007F));

      memValid   = 1'b1;
      memTarget  = 1'b0;
      memData    = 32'h1234_5678;
      cBus       = 32'hAAAA_5555;
      cWriteMask = 10'b0000000100;
      #1;
      checkOutput("conflict_ready", 320'(memReady), 320'(1'b0));
      applyStimulus();
      cWriteMask = '0;
      #1;
      checkOutput("conflict_mdr_cbus", 320'(regSlice(2)), 320'(32'hAAAA_5555));
      checkOutput("retry_ready", 320'(memReady), 320'(1'b1));
      applyStimulus();
      memValid = 1'b0;
      #1;
      checkOutput("load_mdr", 320'(regSlice(2)), 320'(32'h1234_5678));

      memValid   = 1'b1;
      memTarget  = 1'b1;
      memData    = 32'hA5A5_A5A5;
      cBus       = 32'h0000_0055;
      cWriteMask = 10'b0000010000;
      #1;
      checkOutput("side_write_ready", 320'(memReady), 320'(1'b1));
      applyStimulus();
      memValid   = 1'b0;
      cWriteMask = '0;
      #1;
      checkOutput("load_mbr", 320'(regSlice(3)), 320'(32'hA5A5_A5A5));
      checkOutput("side_write_pc", 320'(regSlice(4)), 320'(32'h0000_0055));

      memTarget = 1'b0;
      memData   = 32'hFFFF_0000;
      applyStimulus();
      checkOutput("idle_mdr_hold", 320'(regSlice(2)), 320'(32'h1234_5678));
      checkOutput("idle_ready", 320'(memReady), 320'(1'b1));

      bEnable = 1'b1;
      bSelect = 4'd12;
      #1;
      checkOutput("badsel_z", 320'(bBus), 320'(zWord));
      checkOutput("badsel_err", 320'(bSelError), 320'(1'b1));
      bEnable = 1'b0;
      #1;
      checkOutput("badsel_off_err", 320'(bSelError), 320'(1'b0));

      memValid  = 1'b1;
      memTarget = 1'b1;
      memData   = 32'hCAFE_F00D;
      reset     = 1'b1;
      #1;
      checkOutput("rst_load_ready", 320'(memReady), 320'(1'b0));
      applyStimulus();
      reset = 1'b0;
      #1;
      checkOutput("rst_load_dropped", 320'(regSlice(3)), 320'(32'h0));
      checkOutput("rst_load_ready_after", 320'(memReady), 320'(1'b1));
      applyStimulus();
      memValid = 1'b0;
      #1;
      checkOutput("rst_load_done", 320'(regSlice(3)), 320'(32'hCAFE_F00D));
      checkOutput("rst_load_h_zero", 320'(aOut), 320'(32'h0));

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
